// File: rtl/rr_mux_reg.sv
// N-channel valid/ready multiplexer with a registered output stage.
// Fixed-select or round-robin arbitration chooses the channel.
module rr_mux_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N = 4,
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      out_sel
);

  logic [SW-1:0]    ptr;
  logic             load_en;
  logic             found;
  logic [SW-1:0]    gidx;
  logic             hi_found;
  logic [SW-1:0]    hi_idx;
  logic             lo_found;
  logic [SW-1:0]    lo_idx;
  logic [WIDTH-1:0] gdata;

  // Grant decision: lowest valid channel above ptr, else lowest valid overall.
  always_comb begin
    load_en  = !out_valid || out_ready;
    found    = 1'b0;
    gidx     = '0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (((in_valid >> i) & N'(1)) != '0) begin
        lo_found = 1'b1;
        lo_idx   = SW'(i);
        if (i > int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = SW'(i);
        end
      end
    end
    if (!reset && load_en) begin
      if (!mode) begin
        found = (int'(sel) < int'(N)) && (((in_valid >> sel) & N'(1)) != '0);
        gidx  = sel;
      end else begin
        found = lo_found;
        gidx  = hi_found ? hi_idx : lo_idx;
      end
    end
  end

  assign in_ready = N'(found) << gidx;
  assign gdata    = WIDTH'(in_data >> (32'(gidx) * WIDTH));

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SW'(N - 1);
    end else if (found) begin
      out_valid <= 1'b1;
      out_data  <= gdata;
      out_sel   <= gidx;
      if (mode) begin
        ptr <= gidx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: directed scenarios followed by random traffic,
// all checked against a queue-free arithmetic reference of the arbitration rules.
module tb_rr_mux_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N = 4;
  localparam int unsigned SW = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               mode;
  logic [SW-1:0]      sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SW-1:0]      out_sel;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_sel;
  int               m_ptr;

  rr_mux_reg #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = N - 1;
  endtask

  // Which channel should win this cycle, -1 for none.
  function automatic int exp_grant();
    int c;
    if (m_valid && !out_ready) return -1;
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 1; k <= int'(N); k++) begin
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] v);
    in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  // Check combinational grant and held outputs, then clock and advance the model.
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    g  = exp_grant();
    er = (g >= 0) ? (N'(1) << g) : '0;
    #1;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = in_data[g*WIDTH +: WIDTH];
      m_sel   = g;
      if (mode) m_ptr = g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; sel = '0; in_data = '0;
    in_valid = 4'b1111; out_ready = 1'b1;
    model_reset();
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fixed select of channel 2
    mode = 1'b0; sel = 2'd2; in_data = 32'h11A5_2233; in_valid = 4'b1111;
    #1;
    chk("fix_ready", 32'(in_ready), 32'b0100);
    cycle();
    chk("fix_data", 32'(out_data), 32'hA5);
    chk("fix_sel", 32'(out_sel), 32'd2);
    chk("fix_valid", 32'(out_valid), 32'd1);

    // Round-robin with all channels valid: 0,1,2,3,0,1
    mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = $urandom;
      cycle();
      chk("rr_order", 32'(out_sel), 32'(k % 4));
    end

    // Sparse round-robin from ptr=1: 3,1,3
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      cycle();
      chk("rr_sparse", 32'(out_sel), (k == 1) ? 32'd1 : 32'd3);
    end

    // Backpressure holding 0x3C
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h5566_773C;
    cycle();
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      in_data = $urandom;
      cycle();
      chk("bp_data", 32'(out_data), 32'h3C);
    end
    out_ready = 1'b1; sel = 2'd1; in_data = 32'h0000_9900;
    cycle();
    chk("bp_reload", 32'(out_data), 32'h99);

    // Mode switch while holding an item from ch1
    mode = 1'b1; in_valid = 4'b0010; in_data = 32'h0000_4200;
    cycle();
    out_ready = 1'b0; mode = 1'b0; sel = 2'd3; in_valid = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("ms_hold", 32'(out_data), 32'h42);
    end
    out_ready = 1'b1; in_data = 32'h7700_0000;
    cycle();
    chk("ms_fixed", 32'(out_sel), 32'd3);
    mode = 1'b1;
    cycle();
    chk("ms_resume", 32'(out_sel), 32'd2);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom % 4) != 0;
      cycle();
    end

    // Asynchronous reset mid-stream with an item held
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    cycle();
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_sel", 32'(out_sel), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    cycle();
    chk("post_rst_first", 32'(out_sel), 32'd0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
